int_log_sched: RTL

INT_LOG_SCHED -- requirements
Module: int_log_sched

---
 rtl/int_log_sched_if.sv | 45 ++++
 rtl/int_log_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/int_log_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : int_log_sched_if
// Description : Two-requester / one-response handshake bundle for the
//               int_log_sched logic-operation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface int_log_sched_if #(
  parameter int DATA_W = 64
);
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_opa;
  logic [DATA_W-1:0] req0_opb;
  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_opa;
  logic [DATA_W-1:0] req1_opb;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  // Requesters plus response consumer
  modport master (
    output req0_valid, req0_op, req0_opa, req0_opb,
    output req1_valid, req1_op, req1_opa, req1_opb,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_err
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_op, req0_opa, req0_opb,
    input  req1_valid, req1_op, req1_opa, req1_opb,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/int_log_sched.sv
`default_nettype none
// ============================================================================
// Module      : int_log_sched
// Description : Two-requester bitwise-logic unit. Grants one requester in
//               IDLE, computes in EXEC, holds the result in RESP until the
//               consumer takes it. Counts completed responses (saturating).
//               Define INT_LOG_SCHED_RR_EN for round-robin arbitration;
//               otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module int_log_sched #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  int_log_sched_if.slave   bus,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic              r_id;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;
  logic [CNT_W-1:0]  r_done_cnt;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic [DATA_W-1:0] w_result;
  logic              w_err;

`ifdef INT_LOG_SCHED_RR_EN
  // Preferred requester on contention; flips away from whoever was just granted
  logic r_rr_ptr;

  // Grant: a lone valid requester wins, on contention the pointer decides
  always_comb begin
    w_gnt0 = bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
    w_gnt1 = bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
  end

  // Pointer update on every acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= w_gnt0;
    end
  end
`else
  // Grant: fixed priority, requester 0 always wins on contention
  always_comb begin
    w_gnt0 = bus.req0_valid;
    w_gnt1 = bus.req1_valid && !bus.req0_valid;
  end
`endif

  assign w_accept       = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
  assign bus.req0_ready = (r_state == S_IDLE) && w_gnt0;
  assign bus.req1_ready = (r_state == S_IDLE) && w_gnt1;

  // Bitwise operation selected by the latched opcode; 111 is illegal
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      3'b000:  w_result = r_opa & r_opb;
      3'b001:  w_result = ~(r_opa & r_opb);
      3'b010:  w_result = r_opa | r_opb;
      3'b011:  w_result = ~(r_opa | r_opb);
      3'b100:  w_result = r_opa ^ r_opb;
      3'b101:  w_result = ~(r_opa ^ r_opb);
      3'b110:  w_result = ~r_opa;
      default: w_err    = 1'b1;
    endcase
  end

  // Scheduler FSM with registered response outputs and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 3'b000;
      r_opa        <= '0;
      r_opb        <= '0;
      r_id         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_done_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= w_gnt0 ? bus.req0_op  : bus.req1_op;
            r_opa   <= w_gnt0 ? bus.req0_opa : bus.req1_opa;
            r_opb   <= w_gnt0 ? bus.req0_opb : bus.req1_opb;
            r_id    <= w_gnt1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_data  <= w_result;
          r_resp_err   <= w_err;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
            if (r_done_cnt != {CNT_W{1'b1}}) begin
              r_done_cnt <= r_done_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign done_cnt       = r_done_cnt;

endmodule
`default_nettype wire
